// File: rtl/byte_word_assembler.sv
// Packs a stream of bytes into DATA_WIDTH-bit words in little- or big-endian lane order.
// Optional macro BYTE_ASM_LAST_EN adds s_last_i/m_last_o/m_keep_o for early word termination.
module byte_word_assembler #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    s_rst_n_i,
  input  logic                    big_endian_i,
  input  logic [7:0]              s_data_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
`ifdef BYTE_ASM_LAST_EN
  input  logic                    s_last_i,
  output logic                    m_last_o,
  output logic [DATA_WIDTH/8-1:0] m_keep_o,
`endif
  output logic [DATA_WIDTH-1:0]   m_data_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int unsigned BYTE_NUM = DATA_WIDTH / 8;
  localparam int unsigned CntW     = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BYTE_NUM - 1);

  logic [CntW-1:0]       byte_cnt_q, byte_cnt_d;
  logic                  order_q, order_d, order_cur;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [CntW-1:0]       lane;
  logic                  final_pos, out_stall, accept, word_end;

`ifdef BYTE_ASM_LAST_EN
  logic [BYTE_NUM-1:0] keep_q, keep_d, m_keep_q, m_keep_d, lane_bit;
  logic                m_last_q, m_last_d;
`endif

  always_comb begin
    out_stall = m_valid_q && !m_ready_i;
`ifdef BYTE_ASM_LAST_EN
    // An early-last byte also completes a word, so it must wait for a free output register.
    final_pos = (byte_cnt_q == LastCnt) || s_last_i;
`else
    final_pos = (byte_cnt_q == LastCnt);
`endif
    s_ready_o = s_rst_n_i && !(out_stall && final_pos);
    accept    = s_valid_i && s_ready_o;
    word_end  = accept && final_pos;
    // Byte order is taken live on byte 0 and from the latched copy afterwards.
    order_cur = (byte_cnt_q == '0) ? big_endian_i : order_q;
    lane      = order_cur ? (LastCnt - byte_cnt_q) : byte_cnt_q;
    lane_data = DATA_WIDTH'(s_data_i) << {lane, 3'b000};
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    order_d    = order_q;
    asm_d      = asm_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q && !m_ready_i;
    if (accept) begin
      order_d = order_cur;
      if (word_end) begin
        byte_cnt_d = '0;
        asm_d      = '0;
        m_data_d   = asm_q | lane_data;
        m_valid_d  = 1'b1;
      end else begin
        byte_cnt_d = byte_cnt_q + CntW'(1);
        asm_d      = asm_q | lane_data;
      end
    end
  end

`ifdef BYTE_ASM_LAST_EN
  always_comb begin
    lane_bit = {{(BYTE_NUM-1){1'b0}}, 1'b1} << lane;
    keep_d   = keep_q;
    m_keep_d = m_keep_q;
    m_last_d = m_last_q;
    if (accept) begin
      if (word_end) begin
        keep_d   = '0;
        m_keep_d = keep_q | lane_bit;
        m_last_d = s_last_i;
      end else begin
        keep_d = keep_q | lane_bit;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) begin
      keep_q   <= '0;
      m_keep_q <= '0;
      m_last_q <= 1'b0;
    end else begin
      keep_q   <= keep_d;
      m_keep_q <= m_keep_d;
      m_last_q <= m_last_d;
    end
  end

  assign m_keep_o = m_keep_q;
  assign m_last_o = m_last_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) begin
      byte_cnt_q <= '0;
      order_q    <= 1'b0;
      asm_q      <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      order_q    <= order_d;
      asm_q      <= asm_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
    end
  end

  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;

endmodule

// File: tb/tb_byte_word_assembler.sv
// Self-checking bench for byte_word_assembler: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based byte/word reference model.
module tb_byte_word_assembler;

  localparam int unsigned DW = 32;
  localparam int unsigned BN = DW / 8;

  logic          clk = 1'b0;
  logic          s_rst_n = 1'b0;
  logic          big_endian = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
`ifdef BYTE_ASM_LAST_EN
  logic          s_last = 1'b0;
  logic          m_last;
  logic [BN-1:0] m_keep;
`endif

  byte_word_assembler #(.DATA_WIDTH(DW)) dut (
    .clk_i       (clk),
    .s_rst_n_i   (s_rst_n),
    .big_endian_i(big_endian),
    .s_data_i    (s_data),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
`ifdef BYTE_ASM_LAST_EN
    .s_last_i    (s_last),
    .m_last_o    (m_last),
    .m_keep_o    (m_keep),
`endif
    .m_data_o    (m_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model: bytes of the word in progress, and completed words awaiting transfer.
  logic [7:0]    cur_bytes[$];
  bit            cur_be;
  logic [DW-1:0] exp_data[$];
  logic [BN-1:0] exp_keep[$];
  bit            exp_last[$];
  bit            last_acc, last_xfer;
  int            valid_cnt, xfer_cnt;

  function automatic logic [DW-1:0] bswap(input logic [DW-1:0] w);
    logic [DW-1:0] r;
    for (int i = 0; i < BN; i++) r[8*i +: 8] = w[DW-8-8*i +: 8];
    return r;
  endfunction

  function automatic logic [BN-1:0] brev(input logic [BN-1:0] k);
    logic [BN-1:0] r;
    for (int i = 0; i < BN; i++) r[i] = k[BN-1-i];
    return r;
  endfunction

  task automatic model_accept(input logic [7:0] b, input bit be, input bit lst);
    logic [DW-1:0] w;
    logic [BN-1:0] k;
    if (cur_bytes.size() == 0) cur_be = be;
    cur_bytes.push_back(b);
    if (cur_bytes.size() == BN || lst) begin
      w = '0;
      k = '0;
      for (int i = 0; i < cur_bytes.size(); i++) begin
        w = w + (DW'(cur_bytes[i]) << (8 * i));
        k[i] = 1'b1;
      end
      if (cur_be) begin
        w = bswap(w);
        k = brev(k);
      end
      exp_data.push_back(w);
      exp_keep.push_back(k);
      exp_last.push_back(lst);
      cur_bytes.delete();
    end
  endtask

  // One clock: sample and check at the falling edge, then advance past the rising edge.
  task automatic step();
    bit lst;
    bit exp_rdy;
    @(negedge clk);
    lst = 1'b0;
`ifdef BYTE_ASM_LAST_EN
    lst = s_last;
`endif
    last_acc  = 1'b0;
    last_xfer = 1'b0;
    check("m_valid", {63'd0, m_valid}, {63'd0, exp_data.size() != 0});
    if (m_valid && exp_data.size() != 0) begin
      check("m_data", 64'(m_data), 64'(exp_data[0]));
`ifdef BYTE_ASM_LAST_EN
      check("m_keep", 64'(m_keep), 64'(exp_keep[0]));
      check("m_last", {63'd0, m_last}, {63'd0, exp_last[0]});
`endif
    end
    if (!s_rst_n) begin
      check("s_ready_rst", {63'd0, s_ready}, 64'd0);
      cur_bytes.delete();
      exp_data.delete();
      exp_keep.delete();
      exp_last.delete();
    end else begin
      exp_rdy = !(m_valid && !m_ready && (cur_bytes.size() == BN - 1 || lst));
      check("s_ready", {63'd0, s_ready}, {63'd0, exp_rdy});
      if (m_valid) valid_cnt++;
      if (m_valid && m_ready && exp_data.size() != 0) begin
        void'(exp_data.pop_front());
        void'(exp_keep.pop_front());
        void'(exp_last.pop_front());
        last_xfer = 1'b1;
        xfer_cnt++;
      end
      if (s_valid && s_ready) begin
        model_accept(s_data, big_endian, lst);
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit be);
    int n;
    s_data  = b;
    big_endian = be;
    s_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_acc && n < 40);
    if (!last_acc) check("send_timeout", 64'd0, 64'd1);
    s_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_s_ready", {63'd0, s_ready}, 64'd0);
    s_rst_n = 1'b1;
    step();

    // Little-endian word, valid one cycle after the final byte
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'h11, 1'b0);
    check("le_not_yet", {63'd0, m_valid}, 64'd0);
    send(8'h22, 1'b0);
    check("le_valid", {63'd0, m_valid}, 64'd1);
    check("le_data", 64'(m_data), 64'h2211BBAA);
    step();

    // Big-endian latched at byte 0, toggles after byte 1 ignored
    send(8'hAA, 1'b1); send(8'hBB, 1'b1); send(8'h11, 1'b0); send(8'h22, 1'b0);
    check("be_data", 64'(m_data), 64'hAABB1122);
    step();

    // Back-pressure: word 2 fills up to its last byte while word 1 is stalled
    m_ready = 1'b0;
    send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0); send(8'hA4, 1'b0);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
    s_data = 8'h04; big_endian = 1'b0; s_valid = 1'b1;
    #1;
    check("bp_ready_low", {63'd0, s_ready}, 64'd0);
    step();
    check("bp_held_data", 64'(m_data), 64'hA4A3A2A1);
    m_ready = 1'b1;
    step();
    check("bp_xfer", {63'd0, last_xfer}, 64'd1);
    check("bp_acc", {63'd0, last_acc}, 64'd1);
    s_valid = 1'b0;
    check("bp_valid2", {63'd0, m_valid}, 64'd1);
    check("bp_data2", 64'(m_data), 64'h04030201);
    step();

    // Reset mid-word discards partial bytes
    send(8'h55, 1'b0); send(8'h66, 1'b0);
    s_rst_n = 1'b0;
    step();
    check("mid_rst_valid", {63'd0, m_valid}, 64'd0);
    check("mid_rst_data", 64'(m_data), 64'd0);
    s_rst_n = 1'b1;
    send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0); send(8'h40, 1'b0);
    check("post_rst_data", 64'(m_data), 64'h40302010);
    step();

    // Streaming: 8 back-to-back bytes, one valid cycle per word
    valid_cnt = 0;
    xfer_cnt  = 0;
    for (int i = 0; i < 8; i++) send(8'(i + 1), 1'b0);
    repeat (3) step();
    check("stream_valid_cycles", 64'(valid_cnt), 64'd2);
    check("stream_words", 64'(xfer_cnt), 64'd2);

`ifdef BYTE_ASM_LAST_EN
    // Early last in both byte orders
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    s_last = 1'b1; send(8'h03, 1'b0); s_last = 1'b0;
    check("last_le_data", 64'(m_data), 64'h00030201);
    check("last_le_keep", 64'(m_keep), 64'b0111);
    check("last_le_last", {63'd0, m_last}, 64'd1);
    step();
    send(8'h01, 1'b1); send(8'h02, 1'b1);
    s_last = 1'b1; send(8'h03, 1'b1); s_last = 1'b0;
    check("last_be_data", 64'(m_data), 64'h01020300);
    check("last_be_keep", 64'(m_keep), 64'b1110);
    step();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      s_rst_n    = ($urandom_range(0, 199) != 0);
      s_valid    = ($urandom_range(0, 3) != 0);
      s_data     = 8'($urandom);
      big_endian = 1'($urandom);
      m_ready    = ($urandom_range(0, 2) != 0);
`ifdef BYTE_ASM_LAST_EN
      s_last     = ($urandom_range(0, 4) == 0);
`endif
      step();
    end

    // Drain
    s_rst_n = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
`ifdef BYTE_ASM_LAST_EN
    s_last  = 1'b0;
`endif
    repeat (4) step();
    check("drain_empty", 64'(exp_data.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
